hfrc_capture_sequencer: RTL
===========================

// Module: hfrc_capture_sequencer
// PURPOSE
//  Run-level controller for the HFRC LVDS receiver. Resets the receiver, waits for lane
//  alignment (with timeout/retry), then on each frame start decides whether that frame is
//  written to the frame buffer (decimation, buffer back-pressure). Counts captured and
//  dropped frames and checks the line count of each completed frame.
// PARAMETERS
//  RST_CYCLES     16        cycles rx_sync_reset is held per reset attempt (>=1)
//  ALIGN_TIMEOUT  1000000   cycles allowed for rx_data_aligned after reset release
//  MAX_RETRY      3         reset/align retries before S_ERROR (0 = no retry)
//  DECIM          1         capture 1 of every DECIM frames (1 = every frame, max 256)
//  EXP_LINES      20'd1088  expected line-start count per frame
// PORTS
//  CLK                 in   1   receiver slow clock
//  resetn              in   1   async active-low reset
//  start               in   1   1-cycle pulse: begin capture run (ignored unless S_IDLE/S_ERROR)
//  stop                in   1   1-cycle pulse: end run at next frame boundary
//  fb_ready            in   1   frame buffer can accept a full frame
//  rx_data_aligned     in   1   receiver bitslip alignment done
//  rx_fps_count        in   1   receiver toggle, flips once per frame start
//  rx_num_lines        in   20  receiver line counter (clears at frame start)
//  rx_sync_reset       out  1   sync reset to receiver
//  rx_frame_buffer_rdy out  1   permit receiver to write the next frame
//  busy                out  1   1 in any state except S_IDLE/S_ERROR
//  done                out  1   1-cycle pulse on normal stop completion
//  err_align_timeout   out  1   sticky; set on entering S_ERROR, cleared by start
//  err_line_count      out  1   sticky; frame line count != EXP_LINES, cleared by start
//  frames_captured     out  16  frames written, saturating, cleared by start
//  frames_dropped      out  16  frames lost to !fb_ready on a decimation slot, saturating
//  state_o             out  3   current state encoding (debug)
// BEHAVIOUR
//  Reset: state S_IDLE, rx_sync_reset=1, all other outputs 0, counters/flags 0.
//  All outputs registered. frame_start = (rx_fps_count != fps_q); fps_q, lines_q and
//  fbr_q (= rx_frame_buffer_rdy delayed 1) sample every cycle.
//  States (state_o): S_IDLE=0, S_RX_RESET=1, S_ALIGN=2, S_ARM=3, S_CAPTURE=4, S_ERROR=5.
//  S_IDLE: rx_sync_reset=1. start -> clear counters/flags, retry=0, S_RX_RESET.
//  S_RX_RESET: rx_sync_reset=1 for exactly RST_CYCLES cycles, then 0 and -> S_ALIGN.
//  S_ALIGN: timer counts; rx_data_aligned -> S_ARM, fps_q re-sampled. Timer reaches
//    ALIGN_TIMEOUT: retry<MAX_RETRY -> retry++, S_RX_RESET; else err_align_timeout=1, S_ERROR.
//  S_ARM: rx_frame_buffer_rdy=0; first frame_start (partial frame) -> skip_cnt=0, S_CAPTURE;
//    no line check on this boundary. stop here -> S_IDLE + done immediately.
//  S_CAPTURE: rx_frame_buffer_rdy = fb_ready & (skip_cnt==0) & !stop_pending, next cycle.
//    On frame_start: lines_q != EXP_LINES -> err_line_count=1;
//    fbr_q=1 -> frames_captured++; else if skip_cnt==0 -> frames_dropped++;
//    skip_cnt = (skip_cnt==0) ? DECIM-1 : skip_cnt-1.
//    stop sets stop_pending (forces rx_frame_buffer_rdy=0); next frame_start (counted as
//    above) -> S_IDLE, done=1 for one cycle, rx_sync_reset=1.
//  rx_data_aligned falling in S_CAPTURE/S_ARM: treated as alignment loss -> retry path
//    (same as timeout) from S_RX_RESET; counters kept.
//  S_ERROR: rx_sync_reset=1, busy=0; start re-runs as from S_IDLE.
//  start+stop same cycle: start wins in S_IDLE/S_ERROR, stop wins otherwise.
//  Counters saturate at 16'hFFFF. resetn low mid-run: immediate return to reset values.
// TESTING
//  Reset/start: RST_CYCLES=16, start -> rx_sync_reset high exactly 16 cycles, then low, busy=1.
//  Timeout: never align, ALIGN_TIMEOUT=100, MAX_RETRY=2 -> 3 reset pulses, S_ERROR, err=1.
//  DECIM=3, fb_ready=1, 10 full frames after arm -> frames_captured=4 (frames 0,3,6,9), dropped=0.
//  DECIM=1, fb_ready low for frames 2-3 of 6 -> captured=4, dropped=2.
//  Frame with 1087 lines, EXP_LINES=1088 -> err_line_count=1 at that frame_start, stays set.
//  stop mid-frame -> rx_frame_buffer_rdy=0 next cycle; done at next frame_start; S_IDLE.

Source files
------------

// File: rtl/hfrc_capture_sequencer.sv
// Run-level controller for the HFRC LVDS receiver: receiver reset, lane alignment with retry,
// per-frame capture decision (decimation, frame-buffer back-pressure), frame statistics.
module hfrc_capture_sequencer #(
    parameter int          RST_CYCLES    = 16,
    parameter int          ALIGN_TIMEOUT = 1000000,
    parameter int          MAX_RETRY     = 3,
    parameter int          DECIM         = 1,
    parameter logic [19:0] EXP_LINES     = 20'd1088
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic        fb_ready,
    input  logic        rx_data_aligned,
    input  logic        rx_fps_count,
    input  logic [19:0] rx_num_lines,
    output logic        rx_sync_reset,
    output logic        rx_frame_buffer_rdy,
    output logic        busy,
    output logic        done,
    output logic        err_align_timeout,
    output logic        err_line_count,
    output logic [15:0] frames_captured,
    output logic [15:0] frames_dropped,
    output logic [2:0]  state_o
);

    localparam int       TW          = $clog2(ALIGN_TIMEOUT + 1);
    localparam int       RCW         = $clog2(RST_CYCLES + 1);
    localparam logic [7:0] SKIP_RELOAD = 8'(DECIM - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RX_RESET = 3'd1,
        S_ALIGN    = 3'd2,
        S_ARM      = 3'd3,
        S_CAPTURE  = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t          state;
    logic            fps_q;
    logic [19:0]     lines_q;
    logic            fbr_q;
    logic [RCW-1:0]  rst_cnt;
    logic [TW-1:0]   timer;
    logic [7:0]      retry;
    logic [7:0]      skip_cnt;
    logic            stop_pending;

    logic            frame_start;
    logic [7:0]      skip_nxt;
    logic            cap_rdy;
    logic            retry_ok;
    logic            align_fail;
    logic [15:0]     captured_inc;
    logic [15:0]     dropped_inc;

    assign state_o     = state;
    assign frame_start = rx_fps_count ^ fps_q;
    assign retry_ok    = (retry < 8'(MAX_RETRY));

    // Permission for the frame about to start uses the post-boundary slot counter,
    // so a skipped slot never sees a one-cycle rdy glitch at its start.
    assign skip_nxt = !frame_start     ? skip_cnt :
                      (skip_cnt == 8'd0) ? SKIP_RELOAD : skip_cnt - 8'd1;
    assign cap_rdy  = fb_ready & (skip_nxt == 8'd0) & ~(stop_pending | stop);

    assign captured_inc = (frames_captured == 16'hFFFF) ? frames_captured : frames_captured + 16'd1;
    assign dropped_inc  = (frames_dropped == 16'hFFFF) ? frames_dropped : frames_dropped + 16'd1;

    // Alignment loss while armed or capturing takes the same retry path as a timeout;
    // a stop in S_ARM ends the run instead.
    assign align_fail = ((state == S_ALIGN) && !rx_data_aligned && (timer == TW'(ALIGN_TIMEOUT - 1)))
                     || ((state == S_ARM) && !rx_data_aligned && !stop)
                     || ((state == S_CAPTURE) && !rx_data_aligned);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state               <= S_IDLE;
            fps_q               <= 1'b0;
            lines_q             <= 20'd0;
            fbr_q               <= 1'b0;
            rst_cnt             <= '0;
            timer               <= '0;
            retry               <= 8'd0;
            skip_cnt            <= 8'd0;
            stop_pending        <= 1'b0;
            rx_sync_reset       <= 1'b1;
            rx_frame_buffer_rdy <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err_align_timeout   <= 1'b0;
            err_line_count      <= 1'b0;
            frames_captured     <= 16'd0;
            frames_dropped      <= 16'd0;
        end else begin
            fps_q   <= rx_fps_count;
            lines_q <= rx_num_lines;
            fbr_q   <= rx_frame_buffer_rdy;
            done    <= 1'b0;

            case (state)
                S_IDLE, S_ERROR: begin
                    rx_sync_reset       <= 1'b1;
                    rx_frame_buffer_rdy <= 1'b0;
                    busy                <= 1'b0;
                    if (start) begin
                        frames_captured   <= 16'd0;
                        frames_dropped    <= 16'd0;
                        err_align_timeout <= 1'b0;
                        err_line_count    <= 1'b0;
                        retry             <= 8'd0;
                        skip_cnt          <= 8'd0;
                        stop_pending      <= 1'b0;
                        rst_cnt           <= '0;
                        busy              <= 1'b1;
                        state             <= S_RX_RESET;
                    end
                end

                S_RX_RESET: begin
                    rx_sync_reset       <= 1'b1;
                    rx_frame_buffer_rdy <= 1'b0;
                    if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                        rx_sync_reset <= 1'b0;
                        timer         <= '0;
                        state         <= S_ALIGN;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end

                S_ALIGN: begin
                    if (rx_data_aligned) begin
                        state <= S_ARM;
                    end else if (timer != TW'(ALIGN_TIMEOUT - 1)) begin
                        timer <= timer + TW'(1);
                    end
                end

                S_ARM: begin
                    rx_frame_buffer_rdy <= 1'b0;
                    if (stop) begin
                        rx_sync_reset <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_IDLE;
                    end else if (frame_start) begin
                        // First boundary closes a partial frame: nothing counted or checked.
                        skip_cnt            <= 8'd0;
                        rx_frame_buffer_rdy <= fb_ready;
                        state               <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    rx_frame_buffer_rdy <= cap_rdy;
                    skip_cnt            <= skip_nxt;
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (frame_start) begin
                        if (lines_q != EXP_LINES) begin
                            err_line_count <= 1'b1;
                        end
                        if (fbr_q) begin
                            frames_captured <= captured_inc;
                        end else if (skip_cnt == 8'd0) begin
                            frames_dropped <= dropped_inc;
                        end
                        if (stop_pending) begin
                            stop_pending        <= 1'b0;
                            rx_frame_buffer_rdy <= 1'b0;
                            rx_sync_reset       <= 1'b1;
                            busy                <= 1'b0;
                            done                <= 1'b1;
                            state               <= S_IDLE;
                        end
                    end
                end

                default: begin
                    rx_sync_reset <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase

            if (align_fail) begin
                rx_frame_buffer_rdy <= 1'b0;
                rx_sync_reset       <= 1'b1;
                stop_pending        <= 1'b0;
                rst_cnt             <= '0;
                if (retry_ok) begin
                    retry <= retry + 8'd1;
                    state <= S_RX_RESET;
                end else begin
                    err_align_timeout <= 1'b1;
                    busy              <= 1'b0;
                    state             <= S_ERROR;
                end
            end
        end
    end

endmodule
